// File: rtl/haar_mem_pkg.sv
// Shared types and constants for the Haar integral-image memory blocks.
package haar_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int DEF_IWIDTH  = 64;
    localparam int DEF_IHEIGHT = 48;
    localparam int DEF_WIN_H   = 24;
    localparam int DEF_SUM_W   = 20;

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/integral_row_store.sv
// Slot-indexed integral row RAM: one write port, NRD combinational read ports.
module integral_row_store
    import haar_mem_pkg::*;
#(
    parameter int W      = 20,
    parameter int IWIDTH = 64,
    parameter int SLOTS  = 26,
    parameter int SLOT_W = 5,
    parameter int X_W    = 6,
    parameter int NRD    = 5
) (
    input  logic                        clk_i,
    input  logic                        wr_en_i,
    input  logic [SLOT_W-1:0]           wr_slot_i,
    input  logic [X_W-1:0]              wr_x_i,
    input  logic [W-1:0]                wr_data_i,
    input  logic [NRD-1:0][SLOT_W-1:0]  rd_slot_i,
    input  logic [NRD-1:0][X_W-1:0]     rd_x_i,
    output logic [NRD-1:0][W-1:0]       rd_data_o
);

    localparam int DEPTH = SLOTS * IWIDTH;
    localparam int AW    = clog2(DEPTH);
    localparam logic [X_W-1:0] XLAST = X_W'(IWIDTH - 1);

    logic [W-1:0] mem_q [DEPTH];

    function automatic logic [AW-1:0] addr_of(input logic [SLOT_W-1:0] slot,
                                              input logic [X_W-1:0]    x);
        return AW'(slot) * AW'(IWIDTH) + AW'(x);
    endfunction

    // Row write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_of(wr_slot_i, wr_x_i)] <= wr_data_i;
        end
    end

    // Asynchronous reads; columns past the row end read as zero.
    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_x_i[p] <= XLAST) begin
                rd_data_o[p] = mem_q[addr_of(rd_slot_i[p], rd_x_i[p])];
            end else begin
                rd_data_o[p] = '0;
            end
        end
    end

endmodule

// File: rtl/integral_window_buffer.sv
// Streaming integral-image generator with a circular store of the last WIN_H+1 rows.
// Optional squared-integral path enabled by defining INTEGRAL_SQ_SUM_EN.
module integral_window_buffer
    import haar_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IWIDTH     = DEF_IWIDTH,
    parameter int IHEIGHT    = DEF_IHEIGHT,
    parameter int WIN_H      = DEF_WIN_H,
    parameter int SUM_W      = DEF_SUM_W,
    parameter int X_W        = 6,
    parameter int Y_W        = 6,
    parameter int OFF_W      = 5
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    input  logic                  i_frame_start,
    input  logic                  i_pixel_valid,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    output logic                  o_pixel_ready,
    input  logic [X_W-1:0]        i_rd_x_a,
    input  logic [X_W-1:0]        i_rd_x_b,
    input  logic [X_W-1:0]        i_rd_x_c,
    input  logic [X_W-1:0]        i_rd_x_d,
    input  logic [OFF_W-1:0]      i_rd_off_a,
    input  logic [OFF_W-1:0]      i_rd_off_b,
    input  logic [OFF_W-1:0]      i_rd_off_c,
    input  logic [OFF_W-1:0]      i_rd_off_d,
    output logic [SUM_W-1:0]      o_rd_data_a,
    output logic [SUM_W-1:0]      o_rd_data_b,
    output logic [SUM_W-1:0]      o_rd_data_c,
    output logic [SUM_W-1:0]      o_rd_data_d,
    output logic [Y_W-1:0]        o_row_count,
    output logic                  o_window_ready,
    output logic                  o_row_done,
    output logic                  o_frame_done
`ifdef INTEGRAL_SQ_SUM_EN
    ,
    output logic [2*SUM_W-1:0]    o_rd_sq_a,
    output logic [2*SUM_W-1:0]    o_rd_sq_b,
    output logic [2*SUM_W-1:0]    o_rd_sq_c,
    output logic [2*SUM_W-1:0]    o_rd_sq_d
`endif
);

    localparam int SLOTS  = WIN_H + 2;
    localparam int SLOT_W = clog2(SLOTS);
    localparam int NRD    = 5;
    localparam int ABOVE  = 4;
    localparam logic [X_W-1:0]    XLAST     = X_W'(IWIDTH - 1);
    localparam logic [Y_W-1:0]    YLAST     = Y_W'(IHEIGHT - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    state_e              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [SUM_W-1:0]    row_acc_q, row_acc_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [Y_W-1:0]      row_count_q, row_count_d;
    logic                win_rdy_q, win_rdy_d;
    logic                row_done_q, row_done_d;
    logic                frame_done_q, frame_done_d;
    logic [SUM_W-1:0]    rd_q [4];

    logic                accept_s, wr_en_s;
    logic [SUM_W-1:0]    row_sum_s, ii_s;
    logic [3:0]          corner_ok_s;
    logic [3:0][OFF_W-1:0]        rd_off_s;
    logic [NRD-1:0][SLOT_W-1:0]   rd_slot_s;
    logic [NRD-1:0][X_W-1:0]      rd_x_s;
    logic [NRD-1:0][SUM_W-1:0]    rd_word_s;

    // Offset 0 is the slot just behind the write slot; larger offsets walk further back.
    function automatic logic [SLOT_W-1:0] corner_slot(input logic [SLOT_W-1:0] wr,
                                                      input logic [OFF_W-1:0]  off);
        int o;
        int s;
        o = int'(off);
        if (o > WIN_H) begin
            o = WIN_H;
        end
        s = int'(wr) - 1 - o;
        if (s < 0) begin
            s = s + SLOTS;
        end
        return SLOT_W'(s);
    endfunction

    // Read-port addressing and zero-border qualification.
    always_comb begin
        rd_x_s   = '0;
        rd_slot_s = '0;
        rd_off_s = '0;
        corner_ok_s = '0;
        rd_x_s[0] = i_rd_x_a;   rd_off_s[0] = i_rd_off_a;
        rd_x_s[1] = i_rd_x_b;   rd_off_s[1] = i_rd_off_b;
        rd_x_s[2] = i_rd_x_c;   rd_off_s[2] = i_rd_off_c;
        rd_x_s[3] = i_rd_x_d;   rd_off_s[3] = i_rd_off_d;
        for (int p = 0; p < 4; p++) begin
            rd_slot_s[p]   = corner_slot(slot_q, rd_off_s[p]);
            corner_ok_s[p] = (int'(rd_off_s[p]) < int'(row_count_q)) &&
                             (int'(rd_off_s[p]) <= WIN_H) &&
                             (int'(rd_x_s[p]) < IWIDTH);
        end
        rd_x_s[ABOVE]    = x_q;
        rd_slot_s[ABOVE] = (slot_q == '0) ? SLOT_LAST : slot_q - SLOT_W'(1);
    end

    // Accumulator datapath; i_frame_start blocks acceptance in the same cycle.
    always_comb begin
        o_pixel_ready = (state_q == ACTIVE) && !i_frame_start;
        accept_s      = o_pixel_ready && i_pixel_valid;
        row_sum_s     = ((x_q == '0) ? '0 : row_acc_q) + SUM_W'(i_pixel);
        ii_s          = row_sum_s + ((y_q == '0) ? '0 : rd_word_s[ABOVE]);
    end

    // Frame FSM, raster counters and row-completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        row_acc_d    = row_acc_q;
        slot_d       = slot_q;
        row_count_d  = row_count_q;
        win_rdy_d    = win_rdy_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        wr_en_s      = 1'b0;
        if (i_frame_start) begin
            state_d     = ACTIVE;
            x_d         = '0;
            y_d         = '0;
            row_acc_d   = '0;
            slot_d      = '0;
            row_count_d = '0;
            win_rdy_d   = 1'b0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (accept_s) begin
                        wr_en_s   = 1'b1;
                        row_acc_d = row_sum_s;
                        if (x_q == XLAST) begin
                            x_d         = '0;
                            row_done_d  = 1'b1;
                            row_count_d = row_count_q + Y_W'(1);
                            slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
                            if (int'(row_count_q) == WIN_H) begin
                                win_rdy_d = 1'b1;
                            end else begin
                                win_rdy_d = win_rdy_q;
                            end
                            if (y_q == YLAST) begin
                                frame_done_d = 1'b1;
                                state_d      = DONE;
                            end else begin
                                y_d = y_q + Y_W'(1);
                            end
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end else begin
                        state_d = ACTIVE;
                    end
                end
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            row_acc_q    <= '0;
            slot_q       <= '0;
            row_count_q  <= '0;
            win_rdy_q    <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int p = 0; p < 4; p++) begin
                rd_q[p] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_acc_q    <= row_acc_d;
            slot_q       <= slot_d;
            row_count_q  <= row_count_d;
            win_rdy_q    <= win_rdy_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            for (int p = 0; p < 4; p++) begin
                rd_q[p] <= corner_ok_s[p] ? rd_word_s[p] : '0;
            end
        end
    end

    integral_row_store #(
        .W(SUM_W), .IWIDTH(IWIDTH), .SLOTS(SLOTS), .SLOT_W(SLOT_W), .X_W(X_W), .NRD(NRD)
    ) u_sum_store (
        .clk_i     (clk_os),
        .wr_en_i   (wr_en_s),
        .wr_slot_i (slot_q),
        .wr_x_i    (x_q),
        .wr_data_i (ii_s),
        .rd_slot_i (rd_slot_s),
        .rd_x_i    (rd_x_s),
        .rd_data_o (rd_word_s)
    );

    assign o_rd_data_a    = rd_q[0];
    assign o_rd_data_b    = rd_q[1];
    assign o_rd_data_c    = rd_q[2];
    assign o_rd_data_d    = rd_q[3];
    assign o_row_count    = row_count_q;
    assign o_window_ready = win_rdy_q;
    assign o_row_done     = row_done_q;
    assign o_frame_done   = frame_done_q;

`ifdef INTEGRAL_SQ_SUM_EN
    localparam int SQ_W = 2 * SUM_W;

    logic [SQ_W-1:0]             sq_acc_q, sq_acc_d, sq_sum_s, sq_ii_s;
    logic [2*DATA_WIDTH-1:0]     pix_sq_s;
    logic [NRD-1:0][SQ_W-1:0]    rd_sq_word_s;
    logic [SQ_W-1:0]             rd_sq_q [4];

    // Squared-pixel accumulator mirroring the plain sum path.
    always_comb begin
        pix_sq_s = {{DATA_WIDTH{1'b0}}, i_pixel} * {{DATA_WIDTH{1'b0}}, i_pixel};
        sq_sum_s = ((x_q == '0) ? '0 : sq_acc_q) + SQ_W'(pix_sq_s);
        sq_ii_s  = sq_sum_s + ((y_q == '0) ? '0 : rd_sq_word_s[ABOVE]);
        if (i_frame_start) begin
            sq_acc_d = '0;
        end else if (accept_s) begin
            sq_acc_d = sq_sum_s;
        end else begin
            sq_acc_d = sq_acc_q;
        end
    end

    // Squared accumulator and squared corner outputs.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            sq_acc_q <= '0;
            for (int p = 0; p < 4; p++) begin
                rd_sq_q[p] <= '0;
            end
        end else begin
            sq_acc_q <= sq_acc_d;
            for (int p = 0; p < 4; p++) begin
                rd_sq_q[p] <= corner_ok_s[p] ? rd_sq_word_s[p] : '0;
            end
        end
    end

    integral_row_store #(
        .W(SQ_W), .IWIDTH(IWIDTH), .SLOTS(SLOTS), .SLOT_W(SLOT_W), .X_W(X_W), .NRD(NRD)
    ) u_sq_store (
        .clk_i     (clk_os),
        .wr_en_i   (wr_en_s),
        .wr_slot_i (slot_q),
        .wr_x_i    (x_q),
        .wr_data_i (sq_ii_s),
        .rd_slot_i (rd_slot_s),
        .rd_x_i    (rd_x_s),
        .rd_data_o (rd_sq_word_s)
    );

    assign o_rd_sq_a = rd_sq_q[0];
    assign o_rd_sq_b = rd_sq_q[1];
    assign o_rd_sq_c = rd_sq_q[2];
    assign o_rd_sq_d = rd_sq_q[3];
`endif

endmodule
